// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle control FSM: state encodings, opcodes
// and the datapath select encodings also consumed by the ALU decoder.
package mc_ctrl_defs;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_I_EXEC    = 4'd8,
        S_I_WB      = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11,
        S_TRAP      = 4'd12
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] ALU_SRC_B_REG    = 2'b00;
    localparam logic [1:0] ALU_SRC_B_FOUR   = 2'b01;
    localparam logic [1:0] ALU_SRC_B_IMM    = 2'b10;
    localparam logic [1:0] ALU_SRC_B_IMM_SH = 2'b11;

    // Dispatch target out of DECODE; anything unrecognised lands in TRAP.
    function automatic state_t decode_next(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW: return S_MEM_ADDR;
            OP_R:         return S_R_EXEC;
            OP_ADDI:      return S_I_EXEC;
            OP_BEQ:       return S_BRANCH;
            OP_J:         return S_JUMP;
            default:      return S_TRAP;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational state-to-control decode for the multi-cycle datapath; the
// mem_ready/alu_zero terms give the Mealy write enables in FETCH and BRANCH.
module mc_ctrl_outdec
    import mc_ctrl_defs::*;
(
    input  logic               rst,
    input  logic [STATE_W-1:0] state,
    input  logic               mem_ready,
    input  logic               alu_zero,
    output logic               mem_req,
    output logic               mem_we,
    output logic               iord,
    output logic               ir_we,
    output logic               pc_we,
    output logic [1:0]         pc_src,
    output logic               reg_we,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path through
        // the block leaves a value unassigned, which would infer a latch.
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = PC_SRC_ALU;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = ALU_SRC_B_REG;
        alu_op     = ALU_OP_ADD;

        if (!rst) begin
            case (state_t'(state))
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = ALU_SRC_B_FOUR;
                    ir_we     = mem_ready;
                    pc_we     = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = ALU_SRC_B_IMM_SH;
                end
                S_MEM_ADDR, S_I_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = ALU_SRC_B_IMM;
                end
                S_MEM_READ: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                end
                S_MEM_WB: begin
                    reg_we     = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEM_WRITE: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    mem_we  = 1'b1;
                end
                S_R_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_OP_FUNCT;
                end
                S_R_WB: begin
                    reg_we  = 1'b1;
                    reg_dst = 1'b1;
                end
                S_I_WB: begin
                    reg_we = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_OP_SUB;
                    pc_src    = PC_SRC_ALUOUT;
                    pc_we     = alu_zero;
                end
                S_JUMP: begin
                    pc_src = PC_SRC_JUMP;
                    pc_we  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle datapath controller: state register, next-state logic, sticky
// illegal-opcode trap and retired-instruction counter.
module multicycle_ctrl
    import mc_ctrl_defs::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             reg_we,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic             is_store;
    logic             illegal_q;
    logic [CNT_W-1:0] retired_q;
    state_t           dec_target;

    assign dec_target = decode_next(opcode);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state     <= S_FETCH;
            is_store  <= 1'b0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            case (state)
                S_FETCH: if (mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    // Load vs store is latched here; opcode is not trusted later.
                    state    <= dec_target;
                    is_store <= (opcode == OP_SW);
                    if (dec_target == S_TRAP) illegal_q <= 1'b1;
                end
                S_MEM_ADDR: state <= is_store ? S_MEM_WRITE : S_MEM_READ;
                S_MEM_READ: if (mem_ready) state <= S_MEM_WB;
                S_MEM_WRITE: begin
                    if (mem_ready) begin
                        state     <= S_FETCH;
                        retired_q <= retired_q + CNT_ONE;
                    end
                end
                S_R_EXEC: state <= S_R_WB;
                S_I_EXEC: state <= S_I_WB;
                S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: begin
                    state     <= S_FETCH;
                    retired_q <= retired_q + CNT_ONE;
                end
                S_TRAP: state <= S_TRAP;
                default: state <= S_FETCH;
            endcase
        end
    end

    mc_ctrl_outdec u_outdec (
        .rst        (rst),
        .state      (state),
        .mem_ready  (mem_ready),
        .alu_zero   (alu_zero),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_src     (pc_src),
        .reg_we     (reg_we),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op)
    );

    // Reset forces every output low, including the registered status outputs.
    assign illegal = illegal_q & ~rst;
    assign retired = rst ? '0 : retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each cycle pushes the expected control
// vector and retired count, then pops and compares it at the falling edge.
module tb_multicycle_ctrl;

    localparam int CW = 4;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    // {req, we, iord, ir_we, pc_we, pc_src, reg_we, reg_dst, mem_to_reg, src_a, src_b, alu_op, illegal}
    localparam logic [15:0] C_ZERO  = 16'b0_0_0_0_0_00_0_0_0_0_00_00_0;
    localparam logic [15:0] C_FWAIT = 16'b1_0_0_0_0_00_0_0_0_0_01_00_0;
    localparam logic [15:0] C_FGO   = 16'b1_0_0_1_1_00_0_0_0_0_01_00_0;
    localparam logic [15:0] C_DEC   = 16'b0_0_0_0_0_00_0_0_0_0_11_00_0;
    localparam logic [15:0] C_MADDR = 16'b0_0_0_0_0_00_0_0_0_1_10_00_0;
    localparam logic [15:0] C_MRD   = 16'b1_0_1_0_0_00_0_0_0_0_00_00_0;
    localparam logic [15:0] C_MWB   = 16'b0_0_0_0_0_00_1_0_1_0_00_00_0;
    localparam logic [15:0] C_MWR   = 16'b1_1_1_0_0_00_0_0_0_0_00_00_0;
    localparam logic [15:0] C_REX   = 16'b0_0_0_0_0_00_0_0_0_1_00_10_0;
    localparam logic [15:0] C_RWB   = 16'b0_0_0_0_0_00_1_1_0_0_00_00_0;
    localparam logic [15:0] C_IEX   = 16'b0_0_0_0_0_00_0_0_0_1_10_00_0;
    localparam logic [15:0] C_IWB   = 16'b0_0_0_0_0_00_1_0_0_0_00_00_0;
    localparam logic [15:0] C_BRT   = 16'b0_0_0_0_1_01_0_0_0_1_00_01_0;
    localparam logic [15:0] C_BRNT  = 16'b0_0_0_0_0_01_0_0_0_1_00_01_0;
    localparam logic [15:0] C_JMP   = 16'b0_0_0_0_1_10_0_0_0_0_00_00_0;
    localparam logic [15:0] C_TRAP  = 16'b0_0_0_0_0_00_0_0_0_0_00_00_1;

    typedef struct {
        logic        r;
        logic [5:0]  op;
        logic        rdy;
        logic        z;
        logic [15:0] ctrl;
        bit          ret;
    } row_t;

    typedef struct packed {
        logic [15:0]   ctrl;
        logic [CW-1:0] ret;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    opcode;
    logic          alu_zero;
    logic          mem_ready;
    logic          mem_req, mem_we, iord, ir_we, pc_we;
    logic [1:0]    pc_src;
    logic          reg_we, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0]    alu_src_b, alu_op;
    logic          illegal;
    logic [CW-1:0] retired;

    exp_t          exp_q[$];
    logic [CW-1:0] model_ret;
    int            checks = 0;
    int            errors = 0;

    wire [15:0] obs = {mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_we,
                       reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal};

    always #5 clk = ~clk;

    multicycle_ctrl #(.CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .alu_zero   (alu_zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_src     (pc_src),
        .reg_we     (reg_we),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .illegal    (illegal),
        .retired    (retired)
    );

    function automatic row_t mk(input logic r, input logic [5:0] op, input logic rdy,
                                input logic z, input logic [15:0] ctrl, input bit ret);
        row_t x;
        x.r = r; x.op = op; x.rdy = rdy; x.z = z; x.ctrl = ctrl; x.ret = ret;
        return x;
    endfunction

    // Applies one cycle of stimulus and records what the outputs must show.
    task automatic drive(input row_t x);
        exp_t e;
        e.ctrl = x.ctrl;
        e.ret  = x.r ? '0 : model_ret;
        exp_q.push_back(e);
        if (x.r)        model_ret = '0;
        else if (x.ret) model_ret = model_ret + 1'b1;
        rst       = x.r;
        opcode    = x.op;
        mem_ready = x.rdy;
        alu_zero  = x.z;
    endtask

    task automatic test_reset();
        row_t rows[$];
        exp_t e;
        rows.push_back(mk(1, OP_R, 1, 0, C_ZERO, 0));
        rows.push_back(mk(1, OP_R, 1, 0, C_ZERO, 0));
        rows.push_back(mk(0, OP_R, 0, 0, C_FWAIT, 0));
        foreach (rows[i]) begin
            drive(rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e.ctrl || retired !== e.ret) begin
                errors++;
                $display("FAIL reset[%0d]: ctrl=%b want %b retired=%0d want %0d", i, obs, e.ctrl, retired, e.ret);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_r_addi();
        row_t rows[$];
        exp_t e;
        rows.push_back(mk(0, OP_R,    1, 0, C_FGO, 0));
        rows.push_back(mk(0, OP_R,    1, 0, C_DEC, 0));
        rows.push_back(mk(0, OP_BAD,  1, 0, C_REX, 0));
        rows.push_back(mk(0, OP_BAD,  1, 0, C_RWB, 1));
        rows.push_back(mk(0, OP_ADDI, 1, 0, C_FGO, 0));
        rows.push_back(mk(0, OP_ADDI, 1, 0, C_DEC, 0));
        rows.push_back(mk(0, OP_ADDI, 1, 0, C_IEX, 0));
        rows.push_back(mk(0, OP_ADDI, 1, 0, C_IWB, 1));
        foreach (rows[i]) begin
            drive(rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e.ctrl || retired !== e.ret) begin
                errors++;
                $display("FAIL r_addi[%0d]: ctrl=%b want %b retired=%0d want %0d", i, obs, e.ctrl, retired, e.ret);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lw_wait();
        row_t rows[$];
        exp_t e;
        rows.push_back(mk(0, OP_LW,  1, 0, C_FGO, 0));
        rows.push_back(mk(0, OP_LW,  1, 0, C_DEC, 0));
        rows.push_back(mk(0, OP_SW,  1, 0, C_MADDR, 0));
        rows.push_back(mk(0, OP_SW,  0, 0, C_MRD, 0));
        rows.push_back(mk(0, OP_SW,  0, 0, C_MRD, 0));
        rows.push_back(mk(0, OP_SW,  0, 0, C_MRD, 0));
        rows.push_back(mk(0, OP_SW,  1, 0, C_MRD, 0));
        rows.push_back(mk(0, OP_SW,  0, 0, C_MWB, 1));
        foreach (rows[i]) begin
            drive(rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e.ctrl || retired !== e.ret) begin
                errors++;
                $display("FAIL lw_wait[%0d]: ctrl=%b want %b retired=%0d want %0d", i, obs, e.ctrl, retired, e.ret);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw_wait();
        row_t rows[$];
        exp_t e;
        rows.push_back(mk(0, OP_SW, 0, 0, C_FWAIT, 0));
        rows.push_back(mk(0, OP_SW, 1, 0, C_FGO, 0));
        rows.push_back(mk(0, OP_SW, 0, 0, C_DEC, 0));
        rows.push_back(mk(0, OP_LW, 0, 0, C_MADDR, 0));
        rows.push_back(mk(0, OP_LW, 0, 0, C_MWR, 0));
        rows.push_back(mk(0, OP_LW, 1, 0, C_MWR, 1));
        rows.push_back(mk(0, OP_LW, 0, 0, C_FWAIT, 0));
        foreach (rows[i]) begin
            drive(rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e.ctrl || retired !== e.ret) begin
                errors++;
                $display("FAIL sw_wait[%0d]: ctrl=%b want %b retired=%0d want %0d", i, obs, e.ctrl, retired, e.ret);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_beq();
        row_t rows[$];
        exp_t e;
        rows.push_back(mk(0, OP_BEQ, 1, 0, C_FGO, 0));
        rows.push_back(mk(0, OP_BEQ, 0, 1, C_DEC, 0));
        rows.push_back(mk(0, OP_BEQ, 0, 1, C_BRT, 1));
        rows.push_back(mk(0, OP_BEQ, 1, 1, C_FGO, 0));
        rows.push_back(mk(0, OP_BEQ, 0, 1, C_DEC, 0));
        rows.push_back(mk(0, OP_BEQ, 1, 0, C_BRNT, 1));
        rows.push_back(mk(0, OP_R,   0, 0, C_FWAIT, 0));
        foreach (rows[i]) begin
            drive(rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e.ctrl || retired !== e.ret) begin
                errors++;
                $display("FAIL beq[%0d]: ctrl=%b want %b retired=%0d want %0d", i, obs, e.ctrl, retired, e.ret);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_trap();
        row_t rows[$];
        exp_t e;
        rows.push_back(mk(0, OP_BAD, 1, 0, C_FGO, 0));
        rows.push_back(mk(0, OP_BAD, 1, 0, C_DEC, 0));
        for (int k = 0; k < 10; k++)
            rows.push_back(mk(0, OP_J, 1'($urandom_range(1)), 1'($urandom_range(1)), C_TRAP, 0));
        rows.push_back(mk(1, OP_J, 1, 0, C_ZERO, 0));
        rows.push_back(mk(0, OP_J, 0, 0, C_FWAIT, 0));
        foreach (rows[i]) begin
            drive(rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e.ctrl || retired !== e.ret) begin
                errors++;
                $display("FAIL trap[%0d]: ctrl=%b want %b retired=%0d want %0d", i, obs, e.ctrl, retired, e.ret);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_in_write();
        row_t rows[$];
        exp_t e;
        rows.push_back(mk(0, OP_ADDI, 1, 0, C_FGO, 0));
        rows.push_back(mk(0, OP_ADDI, 1, 0, C_DEC, 0));
        rows.push_back(mk(0, OP_ADDI, 1, 0, C_IEX, 0));
        rows.push_back(mk(0, OP_ADDI, 1, 0, C_IWB, 1));
        rows.push_back(mk(0, OP_SW,   1, 0, C_FGO, 0));
        rows.push_back(mk(0, OP_SW,   1, 0, C_DEC, 0));
        rows.push_back(mk(0, OP_SW,   0, 0, C_MADDR, 0));
        rows.push_back(mk(0, OP_SW,   0, 0, C_MWR, 0));
        rows.push_back(mk(1, OP_SW,   1, 0, C_ZERO, 0));
        rows.push_back(mk(0, OP_SW,   0, 0, C_FWAIT, 0));
        foreach (rows[i]) begin
            drive(rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e.ctrl || retired !== e.ret) begin
                errors++;
                $display("FAIL rst_in_write[%0d]: ctrl=%b want %b retired=%0d want %0d", i, obs, e.ctrl, retired, e.ret);
            end
            @(posedge clk); #1;
        end
    endtask

    // Sixteen back-to-back jumps from a cleared counter wrap it back to zero.
    task automatic test_back_to_back_wrap();
        row_t rows[$];
        exp_t e;
        for (int k = 0; k < 16; k++) begin
            rows.push_back(mk(0, OP_J, 1, 0, C_FGO, 0));
            rows.push_back(mk(0, OP_J, 1, 0, C_DEC, 0));
            rows.push_back(mk(0, OP_J, 1, 0, C_JMP, 1));
        end
        rows.push_back(mk(0, OP_J, 0, 0, C_FWAIT, 0));
        foreach (rows[i]) begin
            drive(rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e.ctrl || retired !== e.ret) begin
                errors++;
                $display("FAIL wrap[%0d]: ctrl=%b want %b retired=%0d want %0d", i, obs, e.ctrl, retired, e.ret);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (retired !== 4'd0) begin
            errors++;
            $display("FAIL wrap_final: retired=%0d want 0", retired);
        end
    endtask

    initial begin
        model_ret = '0;
        rst       = 1'b1;
        opcode    = OP_R;
        mem_ready = 1'b1;
        alu_zero  = 1'b0;
        test_reset();
        test_r_addi();
        test_lw_wait();
        test_sw_wait();
        test_beq();
        test_trap();
        test_reset_in_write();
        test_back_to_back_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore/Mealy control FSM that sequences the multi-cycle datapath: register file, instruction decoder, ALU decoder, ALU and a shared instruction/data memory.
- Consumes the opcode from the instruction register plus the ALU zero flag.
- Drives every datapath enable/mux select and the 2-bit aluOp into the ALU decoder.
- Handshakes with memory (req/ready) and counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter (wraps modulo 2^CNT_W).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- opcode  in  6  inst[31:26] from instruction register
- alu_zero  in  1  ALU result == 0
- mem_ready  in  1  memory completes access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write (valid with mem_req)
- iord  out  1  0 = address from PC, 1 = from ALU-out register
- ir_we  out  1  load instruction register
- pc_we  out  1  load PC
- pc_src  out  2  00 ALU result, 01 ALU-out reg (branch target), 10 jump target
- reg_we  out  1  register file write
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALU-out, 1 = memory data reg
- alu_src_a  out  1  0 = PC, 1 = regs[rs]
- alu_src_b  out  2  00 regs[rt], 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- alu_op  out  2  00 add, 01 sub, 10 use funct
- illegal  out  1  sticky trap flag
- retired  out  CNT_W  instructions completed

Behaviour:
- States: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP, TRAP.
- Opcodes: R 000000, LW 100011, SW 101011, BEQ 000100, J 000010, ADDI 001000. Any other opcode is illegal.
- Reset: at a clk edge with rst=1, state <= FETCH, illegal <= 0, retired <= 0. While rst=1, all outputs are forced to 0. Reset aborts any in-flight access; mem_req is 0 during reset. Reset overrides everything, including TRAP.
- FETCH:
  - mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - Hold FETCH while mem_ready=0; ir_we and pc_we stay 0 during the wait.
  - When mem_ready=1: ir_we=1 and pc_we=1 in that same cycle (Mealy), then next state is DECODE.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=00 (precompute branch target).
  - Next state by opcode: LW/SW -> MEM_ADDR, R -> R_EXEC, ADDI -> I_EXEC, BEQ -> BRANCH, J -> JUMP, else -> TRAP.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next is MEM_READ (LW) or MEM_WRITE (SW).
- MEM_READ: mem_req=1, iord=1, mem_we=0. Hold until mem_ready=1, then go to MEM_WB.
- MEM_WB: reg_we=1, reg_dst=0, mem_to_reg=1; retire; next FETCH.
- MEM_WRITE: mem_req=1, iord=1, mem_we=1. Hold until mem_ready=1; retire on that cycle; next FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next R_WB.
- R_WB: reg_we=1, reg_dst=1, mem_to_reg=0; retire; next FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00. Next I_WB.
- I_WB: reg_we=1, reg_dst=0, mem_to_reg=0; retire; next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_we=alu_zero (Mealy); retire; next FETCH.
- JUMP: pc_src=10, pc_we=1; retire; next FETCH.
- TRAP: all controls 0 and illegal=1. TRAP is terminal; only rst exits it.
- Retire means retired <= retired+1 at that clock edge. The counter wraps from all-ones to 0.
- Any output not listed for a state is 0.
- Latency with zero-wait memory (mem_ready tied high): R 4 cycles, ADDI 4, LW 5, SW 4, BEQ 3, J 3. Each memory wait cycle adds 1.
- mem_req, iord and mem_we must stay stable until the mem_ready cycle.
- mem_ready sampled outside FETCH/MEM_READ/MEM_WRITE is ignored.
- opcode is read only in DECODE; IR is stable there.

Decomposition:
- Shared package/header mc_ctrl_defs holds:
  - state encodings
  - opcode constants
  - ALU_OP_ADD/SUB/FUNCT (shared with the ALU decoder)
  - PC_SRC and ALU_SRC_B encodings
- Optional sub-module mc_ctrl_outdec: combinational state-to-control decode. The FSM register, next-state logic and counter stay in the top module.

Test Plan:
- rst=1 for 2 cycles with mem_ready=1 -> all outputs 0, retired=0. First cycle after release: mem_req=1, iord=0, alu_src_b=01.
- mem_ready=1, opcode=000000 -> states FETCH, DECODE, R_EXEC, R_WB; reg_we=1 with reg_dst=1 in cycle 4; retired=1.
- LW (100011) with mem_ready low for 3 cycles in MEM_READ -> state holds, mem_req/iord stay 1, reg_we=0; mem_to_reg=1 write one cycle after ready; 8 cycles total.
- BEQ with alu_zero=1, then with alu_zero=0 -> pc_we=1 with pc_src=01 in the first run; pc_we=0 in the second; retired increments in both.
- opcode=111111 -> TRAP and illegal=1, holding 10 cycles with mem_req=0; rst then clears illegal and resumes FETCH.
- Preload retired = 2^CNT_W - 1 (or CNT_W=4 with 16 J instructions) -> wraps to 0. Assert rst during a MEM_WRITE wait -> next cycle mem_req=0, state=FETCH after release.
